// File: rtl/poly_pkg.sv
// Shared types and arithmetic sizing helpers for the Horner polynomial evaluator.
package poly_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} poly_state_e;

  // Accumulator width: holds (acc*x)>>>FBITS plus a coefficient without overflow.
  function automatic int wid_acc(input int wid, input int fbits);
    return (2*wid - fbits + 2 > 32) ? (2*wid - fbits + 2) : 32;
  endfunction

  function automatic longint clamp_max(input int wid);
    return (longint'(1) <<< (wid - 1)) - 1;
  endfunction

  function automatic longint clamp_min(input int wid);
    return -(longint'(1) <<< (wid - 1));
  endfunction

endpackage

// File: rtl/fxp_horner_step.sv
// One Horner step: next = clamp(((acc*x) >>> FBITS) + c), flags when clamping occurred.
module fxp_horner_step
  import poly_pkg::*;
#(
  parameter int WID   = 16,
  parameter int FBITS = 8
) (
  input  logic [WID-1:0] acc_i,
  input  logic [WID-1:0] x_i,
  input  logic [WID-1:0] c_i,
  output logic [WID-1:0] acc_o,
  output logic           clamp_o
);

  localparam int WA = wid_acc(WID, FBITS);
  localparam logic signed [WA-1:0] MAXV = WA'(clamp_max(WID));
  localparam logic signed [WA-1:0] MINV = WA'(clamp_min(WID));

  logic signed [2*WID-1:0] prod;
  logic signed [2*WID-1:0] prod_sh;
  logic signed [WA-1:0]    sum;

  always_comb begin
    prod    = (2*WID)'($signed(acc_i)) * (2*WID)'($signed(x_i));
    prod_sh = prod >>> FBITS;
    sum     = WA'(prod_sh) + WA'($signed(c_i));
    acc_o   = sum[WID-1:0];
    clamp_o = 1'b0;
    if (sum > MAXV) begin
      acc_o   = MAXV[WID-1:0];
      clamp_o = 1'b1;
    end else if (sum < MINV) begin
      acc_o   = MINV[WID-1:0];
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/poly_horner.sv
// Iterative fixed-point polynomial evaluator, one Horner multiply-accumulate per clock.
module poly_horner
  import poly_pkg::*;
#(
  parameter int WID   = 16,
  parameter int FBITS = 8,
  parameter int DEG   = 3,
  localparam int AW   = $clog2(DEG + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           coef_we,
  input  logic [AW-1:0]  coef_addr,
  input  logic [WID-1:0] coef_wdata,
  output logic           coef_err,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] y,
  output logic           sat
);

  poly_state_e           state_q, state_d;
  logic [DEG:0][WID-1:0] coef_q;
  logic [WID-1:0]        acc_q, x_q, step_acc;
  logic [AW-1:0]         k_q;
  logic                  sat_q, out_valid_q, coef_err_q, step_clamp;
  logic                  accept, wr_ok;
  logic [(1<<AW)-1:0]    addr_ok;

  // Address legality as a constant mask avoids range compares that fold to constants.
  for (genvar a = 0; a < (1 << AW); a++) begin : g_addr
    assign addr_ok[a] = (a <= DEG);
  end

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = coef_we && in_ready && addr_ok[coef_addr];

  fxp_horner_step #(.WID(WID), .FBITS(FBITS)) u_step (
    .acc_i   (acc_q),
    .x_i     (x_q),
    .c_i     (coef_q[k_q]),
    .acc_o   (step_acc),
    .clamp_o (step_clamp)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (k_q == '0)   state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      coef_q      <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      k_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
      coef_err_q  <= coef_we && !wr_ok;
      if (wr_ok) coef_q[coef_addr] <= coef_wdata;
      if (accept) begin
        x_q   <= x;
        // A same-cycle write to the leading coefficient must be seen by this sample.
        acc_q <= (wr_ok && coef_addr == AW'(DEG)) ? coef_wdata : coef_q[DEG];
        k_q   <= AW'(DEG - 1);
        sat_q <= 1'b0;
      end else if (state_q == RUN) begin
        acc_q <= step_acc;
        sat_q <= sat_q | step_clamp;
        k_q   <= k_q - AW'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = acc_q;
  assign sat       = sat_q;
  assign coef_err  = coef_err_q;

endmodule
